// File: rtl/dmem_arbiter_if.sv
// Bundle of the two cache request ports and the data-memory port seen by
// dmem_arbiter. The slave modport is the arbiter's view; master is the
// view of whatever drives the caches and models the memory.
`timescale 1ns/100ps
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int LW = 128
);
    // Port 0 (I-cache) and port 1 (D-cache) request side
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wd0;
    logic [DW-1:0] wd1;
    logic          done0;
    logic          done1;
    logic          err;
    logic [LW-1:0] rdata;
    logic          busy;
    // Data-memory side
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic          mem_ready;
    logic [LW-1:0] mem_rd;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wd0, wd1, mem_ready, mem_rd,
        output done0, done1, err, rdata, busy, mem_we, mem_a, mem_wd
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wd0, wd1, mem_ready, mem_rd,
        input  done0, done1, err, rdata, busy, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one block-read data memory between
// the I-cache refill port (0) and the D-cache refill/write-through port (1).
// Word writes take one memory cycle; line reads wait on mem_ready with a
// bounded timeout. Every output is driven straight from a register.
`timescale 1ns/100ps
module dmem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LW      = 128,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_a_q, mem_a_d;
    logic [DW-1:0] mem_wd_q, mem_wd_d;
    logic [LW-1:0] rdata_q, rdata_d;

    logic          gnt_vld;
    logic          gnt;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wd;

    // Pick the winning port: on a tie the port that did not win last time.
    always_comb begin
        gnt_vld = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            gnt = ~last_q;
        end else begin
            gnt = bus.req1;
        end
        sel_we   = gnt ? bus.we1   : bus.we0;
        sel_addr = gnt ? bus.addr1 : bus.addr0;
        sel_wd   = gnt ? bus.wd1   : bus.wd0;
    end

    // Next-state and registered-output logic for the transaction sequencer.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        mem_we_d = mem_we_q;
        mem_a_d  = mem_a_q;
        mem_wd_d = mem_wd_q;
        rdata_d  = rdata_q;

        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (gnt_vld) begin
                    owner_d = gnt;
                    last_d  = gnt;
                    if (sel_we) begin
                        mem_a_d  = sel_addr;
                        mem_wd_d = sel_wd;
                        mem_we_d = 1'b1;
                        state_d  = WR;
                    end else begin
                        // Line reads always start on a 16-byte boundary.
                        mem_a_d  = {sel_addr[AW-1:4], 4'b0000};
                        mem_we_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = RD_WAIT;
                    end
                end
            end
            WR: begin
                // Write strobe lasts one cycle; memory readiness is irrelevant.
                mem_we_d = 1'b0;
                state_d  = RESP;
            end
            RD_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // mem_ready is checked first so it wins a tie with the timeout.
                if (bus.mem_ready) begin
                    rdata_d = bus.mem_rd;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Owner is fixed from grant until RESP, so the pulse follows it.
        done0_d = (state_d == RESP) && !owner_q;
        done1_d = (state_d == RESP) &&  owner_q;
        busy_d  = (state_d != IDLE);
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            mem_we_q <= 1'b0;
            mem_a_q  <= '0;
            mem_wd_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            mem_we_q <= mem_we_d;
            mem_a_q  <= mem_a_d;
            mem_wd_q <= mem_wd_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.done0  = done0_q;
    assign bus.done1  = done1_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy_q;
    assign bus.mem_we = mem_we_q;
    assign bus.mem_a  = mem_a_q;
    assign bus.mem_wd = mem_wd_q;
    assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: scoreboard of expected done responses checked
// by an independent monitor, plus a second instance with a short timeout.
`timescale 1ns/100ps
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW), .LW(LW)) bus ();
    dmem_arbiter_if #(.AW(AW), .DW(DW), .LW(LW)) bus_to ();

    dmem_arbiter #(.AW(AW), .DW(DW), .LW(LW), .TIMEOUT(64)) u_dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    dmem_arbiter #(.AW(AW), .DW(DW), .LW(LW), .TIMEOUT(8)) u_dut_to (
        .clk(clk), .rst(rst), .bus(bus_to.slave)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int            port;
        bit            err;
        logic [LW-1:0] rdata;
    } exp_t;
    exp_t sb[$];

    // Memory model controls for the main instance
    int            resp_delay = -1;
    bit            resp_mode  = 1'b0;
    logic [LW-1:0] resp_line  = '0;
    int            wait_cnt   = 0;
    bit            mema_en    = 1'b0;
    logic [AW-1:0] exp_mema   = '0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int port, input bit err, input logic [LW-1:0] rdata);
        exp_t e;
        e.port  = port;
        e.err   = err;
        e.rdata = rdata;
        return e;
    endfunction

    // Memory returns four consecutive word addresses as the line contents.
    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        return {a + 32'd3, a + 32'd2, a + 32'd1, a};
    endfunction

    // Memory responder: raises mem_ready resp_delay cycles into RD_WAIT.
    always @(negedge clk) begin
        if (bus.busy && !bus.mem_we && !bus.done0 && !bus.done1) begin
            if (resp_delay >= 0 && wait_cnt == resp_delay) begin
                bus.mem_ready = 1'b1;
                bus.mem_rd    = resp_mode ? line_of(bus.mem_a) : resp_line;
            end else begin
                bus.mem_ready = 1'b0;
            end
            wait_cnt++;
        end else begin
            bus.mem_ready = 1'b0;
            wait_cnt      = 0;
        end
    end

    // Monitor: every done pulse is matched against the scoreboard head.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && (bus.done0 || bus.done1)) begin
            check("done_exclusive", {127'd0, bus.done0 & bus.done1}, '0);
            check("busy_with_done", {127'd0, bus.busy}, 128'd1);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done0=%b done1=%b expected no done", bus.done0, bus.done1);
            end else begin
                e = sb.pop_front();
                check("done_port", {126'd0, bus.done1, bus.done0}, (e.port == 1) ? 128'd2 : 128'd1);
                check("done_err", {127'd0, bus.err}, {127'd0, e.err});
                check("done_rdata", bus.rdata, e.rdata);
            end
        end
        if (mema_en && bus.busy && !bus.mem_we && !bus.done0 && !bus.done1)
            check("rd_mem_a", {96'd0, bus.mem_a}, {96'd0, exp_mema});
    end

    task automatic do_req(input int port, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int n;
        @(negedge clk);
        if (port == 0) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wd0 = wd;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wd1 = wd;
        end
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if ((port == 0) ? bus.done0 : bus.done1) break;
            n++;
        end
        if (n >= 300) begin
            tests++;
            fails++;
            $display("FAIL req_timeout port%0d: got no done expected done", port);
        end
        if (port == 0) bus.req0 = 1'b0;
        else           bus.req1 = 1'b0;
    endtask

    initial begin
        int n;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wd0 = '0; bus.wd1 = '0;
        bus_to.req0 = 0; bus_to.req1 = 0; bus_to.we0 = 0; bus_to.we1 = 0;
        bus_to.addr0 = '0; bus_to.addr1 = '0; bus_to.wd0 = '0; bus_to.wd1 = '0;
        bus_to.mem_ready = 0; bus_to.mem_rd = '0;

        rst = 1'b1;
        #1 rst = 1'b0;
        #3;
        check("rst_done0", {127'd0, bus.done0}, '0);
        check("rst_done1", {127'd0, bus.done1}, '0);
        check("rst_err", {127'd0, bus.err}, '0);
        check("rst_busy", {127'd0, bus.busy}, '0);
        check("rst_mem_we", {127'd0, bus.mem_we}, '0);
        check("rst_mem_a", {96'd0, bus.mem_a}, '0);
        check("rst_mem_wd", {96'd0, bus.mem_wd}, '0);
        check("rst_rdata", bus.rdata, '0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", {127'd0, bus.busy}, '0);
        check("idle_mem_we", {127'd0, bus.mem_we}, '0);

        // Port 0 line read at 0x8, memory answers 10 cycles after the grant
        resp_mode  = 1'b0;
        resp_line  = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        resp_delay = 9;
        exp_mema   = 32'h0;
        mema_en    = 1'b1;
        sb.push_back(mk(0, 1'b0, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA));
        do_req(0, 1'b0, 32'h8, 32'h0);
        mema_en    = 1'b0;

        // Port 1 word write; rdata keeps the previous line
        sb.push_back(mk(1, 1'b0, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA));
        fork
            do_req(1, 1'b1, 32'h4, 32'hBBBBBBBB);
            begin
                n = 0;
                while (!bus.mem_we && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("wr_we_seen", {127'd0, bus.mem_we}, 128'd1);
                check("wr_mem_a", {96'd0, bus.mem_a}, 128'h4);
                check("wr_mem_wd", {96'd0, bus.mem_wd}, 128'hBBBBBBBB);
                @(negedge clk);
                check("wr_we_one_cycle", {127'd0, bus.mem_we}, '0);
            end
        join

        // Both ports stream reads: grants alternate starting with port 0
        resp_mode  = 1'b1;
        resp_delay = 2;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(mk(0, 1'b0, 128'h00000103_00000102_00000101_00000100));
            sb.push_back(mk(1, 1'b0, 128'h00000203_00000202_00000201_00000200));
        end
        fork
            begin repeat (4) do_req(0, 1'b0, 32'h100, 32'h0); end
            begin repeat (4) do_req(1, 1'b0, 32'h204, 32'h0); end
        join

        // TIMEOUT=8 instance: mem_ready on the final wait cycle beats the timeout
        @(negedge clk);
        bus_to.req0 = 1'b1; bus_to.addr0 = 32'h40;
        @(negedge clk);
        repeat (7) @(negedge clk);
        bus_to.mem_ready = 1'b1;
        bus_to.mem_rd    = 128'h11112222_33334444_55556666_77778888;
        @(negedge clk);
        check("tie_done0", {127'd0, bus_to.done0}, 128'd1);
        check("tie_err", {127'd0, bus_to.err}, '0);
        check("tie_rdata", bus_to.rdata, 128'h11112222_33334444_55556666_77778888);
        bus_to.mem_ready = 1'b0;
        bus_to.req0 = 1'b0;
        @(negedge clk);
        check("tie_idle", {127'd0, bus_to.busy}, '0);

        // TIMEOUT=8 instance: no mem_ready, done 8 cycles into RD_WAIT
        bus_to.req0 = 1'b1; bus_to.addr0 = 32'h12345678;
        @(negedge clk);
        check("to_busy", {127'd0, bus_to.busy}, 128'd1);
        check("to_mem_a", {96'd0, bus_to.mem_a}, 128'h12345670);
        n = 0;
        while (!bus_to.done0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("to_latency", n, 8);
        check("to_err", {127'd0, bus_to.err}, 128'd1);
        check("to_rdata", bus_to.rdata, '0);
        check("to_done1", {127'd0, bus_to.done1}, '0);
        bus_to.req0 = 1'b0;
        @(negedge clk);
        check("to_idle_busy", {127'd0, bus_to.busy}, '0);
        check("to_idle_err", {127'd0, bus_to.err}, '0);

        // Asynchronous reset in the middle of a port 0 read
        resp_delay = -1;
        @(negedge clk);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h300;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", {127'd0, bus.busy}, 128'd1);
        #2 rst = 1'b0;
        #0.5;
        check("mid_rst_busy", {127'd0, bus.busy}, '0);
        check("mid_rst_mem_a", {96'd0, bus.mem_a}, '0);
        check("mid_rst_done0", {127'd0, bus.done0}, '0);
        check("mid_rst_rdata", bus.rdata, '0);
        sb.delete();
        bus.req0 = 1'b0;
        #0.5 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {127'd0, bus.busy}, '0);

        // After reset a tie goes to port 0 first
        resp_mode  = 1'b1;
        resp_delay = 1;
        sb.push_back(mk(0, 1'b0, 128'h00000303_00000302_00000301_00000300));
        sb.push_back(mk(1, 1'b0, 128'h00000503_00000502_00000501_00000500));
        fork
            do_req(0, 1'b0, 32'h300, 32'h0);
            do_req(1, 1'b0, 32'h508, 32'h0);
        join

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("final_busy", {127'd0, bus.busy}, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter/sequencer sharing the single block-read data memory between the I-cache refill path (port 0) and the D-cache refill/write-through path (port 1).
- Accepts per-port word-write or 128-bit line-read requests and arbitrates them round-robin.
- Drives the memory's WE/A/WD, waits on the memory's READY handshake and returns the line to the winning port with a one-cycle done pulse.
- Sits between the caches and data_memory in the pipelined MIPS memory subsystem.

Parameters:
- AW, 32, address width in bits.
- DW, 32, write-data word width in bits.
- LW, 128, line (read-data) width in bits; 4 words.
- TIMEOUT, 64, maximum cycles spent in RD_WAIT before a read is aborted; must be at least 2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  request from port 0 (I-cache) / port 1 (D-cache); held high until that port's done.
- we0 / we1  in  1  1 = word write, 0 = line read; valid while req is high.
- addr0 / addr1  in  AW  byte address; valid while req is high.
- wd0 / wd1  in  DW  write data; valid while req is high.
- done0 / done1  out  1  one-cycle completion pulse to the owning port.
- err  out  1  high with a done pulse when that read timed out.
- rdata  out  LW  line data returned to ports; valid while a done is high.
- busy  out  1  high in every state except IDLE.
- mem_we  out  1  to memory WE.
- mem_a  out  AW  to memory A.
- mem_wd  out  DW  to memory WD.
- mem_ready  in  1  memory READY; read line valid.
- mem_rd  in  LW  memory RD.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - done0, done1, err, busy, mem_we = 0; mem_a, mem_wd, rdata = 0.
  - Round-robin pointer last = 1, so port 0 wins the first tie.
  - Timeout counter = 0.
  - A reset mid-transaction abandons it with no done pulse; any write already issued to memory stands.
- All outputs are registered.
- States are IDLE, WR, RD_WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the port != last.
  - On grant, at the same edge: latch the owner and set last = owner.
  - Write grant: mem_a = addr, mem_wd = wd, mem_we = 1, go to WR.
  - Read grant: mem_a = {addr[AW-1:4], 4'b0} (line-aligned), mem_we = 0, counter = 0, go to RD_WAIT.
- WR:
  - mem_we is high for exactly this one cycle, so memory writes exactly once.
  - At the next edge: mem_we = 0, go to RESP. mem_ready is ignored for writes.
- RD_WAIT:
  - mem_a is held stable and the counter increments each cycle.
  - mem_ready high at an edge: rdata = mem_rd, err = 0, go to RESP.
  - Else, counter == TIMEOUT-1: rdata = 0, err = 1, go to RESP.
  - If mem_ready and the timeout coincide, mem_ready wins (err = 0).
- RESP:
  - done(owner) = 1 and busy = 1 for exactly one cycle; rdata and err are held.
  - Next edge: done = 0, err = 0, go to IDLE. rdata holds its value until the next read.
  - Requests are not sampled in RESP.
  - The owning port must drop req during the RESP cycle. A req still high in IDLE is treated as a new request.
- Latency:
  - Write: req seen at edge N, done high in cycle N+2 to N+3 (3 edges to IDLE).
  - Read: done high the cycle after the edge that samples mem_ready.
- Fairness: under continuous requests from both ports, grants alternate 0,1,0,1. A lone requester may win back-to-back grants.
- Requests arriving while busy are held by the requester and stay pending; they are not latched early.
- done0 and done1 are never high together.

Test Plan:
- Reset then idle → all outputs 0, busy = 0.
- Port 1 write, addr 0x4, wd 0xBBBBBBBB → mem_we high exactly 1 cycle with mem_a = 0x4 and mem_wd = 0xBBBBBBBB; done1 pulses 1 cycle; done0 stays 0.
- Port 0 read, addr 0x8, memory model asserts mem_ready 10 cycles later with mem_rd = 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA → mem_a = 0x0 throughout, rdata equals that line when done0 is high, err = 0.
- Both ports request reads in the same cycle, repeated 4 times → grant order is 0,1,0,1; never two dones at once.
- Read with mem_ready never asserted, TIMEOUT = 8 → done pulses 8 cycles after entering RD_WAIT with err = 1 and rdata = 0; then IDLE.
- rst driven low for 1 ns mid-RD_WAIT (between clock edges) → outputs clear immediately, no done pulse; after release a new port 0 read is granted first.
